// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - multi-cycle accumulator CPU controller (ADD/AND/INC/JMP)
module acc_cpu_core #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir,
  output logic              carry,
  output logic [1:0]        state,
  output logic              instr_done
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [DATA_W:0]   AC_ONE = (DATA_W + 1)'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              carry_q, carry_d;
  logic              done_q, done_d;

  logic [1:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   inc_sum;

  assign opcode  = ir_q[DATA_W-1 -: 2];
  assign operand = ir_q[ADDR_W-1:0];
  assign add_sum = {1'b0, ac_q} + {1'b0, mem_data};
  assign inc_sum = {1'b0, ac_q} + AC_ONE;

  // With en low nothing advances, and the retire pulse drops on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ac_q    <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (!en) begin
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (opcode == OP_ADD || opcode == OP_AND) ? S_EXEC : S_FETCH;
      S_EXEC:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ac_d     = ac_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    mem_addr = operand;
    case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        ir_d     = mem_data;
        pc_d     = pc_q + PC_ONE;
      end
      S_DECODE: begin
        if (opcode == OP_INC) begin
          ac_d    = inc_sum[DATA_W-1:0];
          carry_d = inc_sum[DATA_W];
          done_d  = 1'b1;
        end else if (opcode == OP_JMP) begin
          pc_d    = operand;
          done_d  = 1'b1;
        end
      end
      S_EXEC: begin
        if (opcode == OP_ADD) begin
          ac_d    = add_sum[DATA_W-1:0];
          carry_d = add_sum[DATA_W];
        end else begin
          ac_d    = ac_q & mem_data;
        end
        done_d = 1'b1;
      end
      default: begin
        mem_addr = pc_q;
      end
    endcase
  end

  assign pc         = pc_q;
  assign ac         = ac_q;
  assign ir         = ir_q;
  assign carry      = carry_q;
  assign state      = state_q;
  assign instr_done = done_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb/tb_acc_cpu_core.sv - directed table-driven bench for acc_cpu_core
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [5:0] mem_addr;
  logic [7:0] mem_data;
  logic [5:0] pc;
  logic [7:0] ac;
  logic [7:0] ir;
  logic       carry;
  logic [1:0] state;
  logic       instr_done;

  logic [7:0] mem [64];
  assign mem_data = mem[mem_addr];

  int errors = 0;
  int checks = 0;

  acc_cpu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .carry      (carry),
    .state      (state),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] pc;
    logic [7:0] ac;
    logic [1:0] st;
    logic       done;
    logic       carry;
    logic [5:0] addr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    en    = 1'b1;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic check_arch(input string tag, input logic [5:0] epc, input logic [7:0] eac,
                            input logic [1:0] est, input logic edone, input logic ecarry);
    check({tag, ".pc"}, 32'(pc), 32'(epc));
    check({tag, ".ac"}, 32'(ac), 32'(eac));
    check({tag, ".state"}, 32'(state), 32'(est));
    check({tag, ".done"}, 32'(instr_done), 32'(edone));
    check({tag, ".carry"}, 32'(carry), 32'(ecarry));
  endtask

  initial begin
    // pc, ac, state, done, carry, mem_addr after each edge of the main program
    vecs[0]  = '{6'd1, 8'h00, 2'd1, 1'b0, 1'b0, 6'd63};
    vecs[1]  = '{6'd1, 8'h00, 2'd2, 1'b0, 1'b0, 6'd63};
    vecs[2]  = '{6'd1, 8'h3F, 2'd0, 1'b1, 1'b0, 6'd1};
    vecs[3]  = '{6'd2, 8'h3F, 2'd1, 1'b0, 1'b0, 6'd62};
    vecs[4]  = '{6'd2, 8'h3F, 2'd2, 1'b0, 1'b0, 6'd62};
    vecs[5]  = '{6'd2, 8'h20, 2'd0, 1'b1, 1'b0, 6'd2};
    vecs[6]  = '{6'd3, 8'h20, 2'd1, 1'b0, 1'b0, 6'd0};
    vecs[7]  = '{6'd3, 8'h21, 2'd0, 1'b1, 1'b0, 6'd3};
    vecs[8]  = '{6'd4, 8'h21, 2'd1, 1'b0, 1'b0, 6'd2};
    vecs[9]  = '{6'd2, 8'h21, 2'd0, 1'b1, 1'b0, 6'd2};
    vecs[10] = '{6'd3, 8'h21, 2'd1, 1'b0, 1'b0, 6'd0};
    vecs[11] = '{6'd3, 8'h22, 2'd0, 1'b1, 1'b0, 6'd3};
    vecs[12] = '{6'd4, 8'h22, 2'd1, 1'b0, 1'b0, 6'd2};
    vecs[13] = '{6'd2, 8'h22, 2'd0, 1'b1, 1'b0, 6'd2};

    // Main program and reset state
    fill_mem(8'h00);
    mem[0] = 8'h3F; mem[1] = 8'h7E; mem[2] = 8'hC0; mem[3] = 8'h82;
    mem[62] = 8'h20; mem[63] = 8'h3F;
    en = 1'b1;
    rst_n = 1'b0;
    #2;
    check_arch("reset", 6'd0, 8'h00, 2'd0, 1'b0, 1'b0);
    check("reset.ir", 32'(ir), 32'h0);
    check("reset.addr", 32'(mem_addr), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check_arch($sformatf("prog.c%0d", i + 1), vecs[i].pc, vecs[i].ac, vecs[i].st,
                 vecs[i].done, vecs[i].carry);
      check($sformatf("prog.c%0d.addr", i + 1), 32'(mem_addr), 32'(vecs[i].addr));
    end

    // Asynchronous reset mid-DECODE, between clock edges
    do_reset();
    ticks(7);
    check("arst.pre_state", 32'(state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_arch("arst", 6'd0, 8'h00, 2'd0, 1'b0, 1'b0);
    check("arst.ir", 32'(ir), 32'h0);
    check("arst.addr", 32'(mem_addr), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst.refetch_ir", 32'(ir), 32'h3F);
    check_arch("arst.refetch", 6'd1, 8'h00, 2'd1, 1'b0, 1'b0);

    // INC wrap with carry
    fill_mem(8'h00);
    mem[0] = 8'h0A; mem[1] = 8'hC0; mem[2] = 8'hC0; mem[10] = 8'hFE;
    do_reset();
    ticks(3);
    check_arch("incw.add", 6'd1, 8'hFE, 2'd0, 1'b1, 1'b0);
    ticks(2);
    check_arch("incw.inc1", 6'd2, 8'hFF, 2'd0, 1'b1, 1'b0);
    ticks(2);
    check_arch("incw.inc2", 6'd3, 8'h00, 2'd0, 1'b1, 1'b1);

    // ADD carry, then AND keeps carry
    fill_mem(8'h00);
    mem[0] = 8'h0A; mem[1] = 8'h0A; mem[2] = 8'h4B; mem[10] = 8'h80; mem[11] = 8'hFF;
    do_reset();
    ticks(3);
    check_arch("addc.a1", 6'd1, 8'h80, 2'd0, 1'b1, 1'b0);
    ticks(3);
    check_arch("addc.a2", 6'd2, 8'h00, 2'd0, 1'b1, 1'b1);
    ticks(3);
    check_arch("addc.and", 6'd3, 8'h00, 2'd0, 1'b1, 1'b1);

    // PC wrap: straight-line INCs through address 63
    fill_mem(8'hC0);
    do_reset();
    ticks(126);
    check("pcw.pc63", 32'(pc), 32'd63);
    check("pcw.addr63", 32'(mem_addr), 32'd63);
    tick();
    check("pcw.pc_wrap", 32'(pc), 32'd0);
    tick();
    check("pcw.ac", 32'(ac), 32'h40);
    check("pcw.addr0", 32'(mem_addr), 32'd0);
    check("pcw.state", 32'(state), 32'd0);
    tick();
    check("pcw.pc1", 32'(pc), 32'd1);

    // en low during EXEC of ADD, then self-looping JMP
    fill_mem(8'h00);
    mem[0] = 8'h0A; mem[1] = 8'h81; mem[10] = 8'h05;
    do_reset();
    ticks(2);
    check("hold.pre_state", 32'(state), 32'd2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_arch($sformatf("hold.c%0d", i), 6'd1, 8'h00, 2'd2, 1'b0, 1'b0);
      check($sformatf("hold.c%0d.ir", i), 32'(ir), 32'h0A);
      check($sformatf("hold.c%0d.addr", i), 32'(mem_addr), 32'd10);
    end
    en = 1'b1;
    tick();
    check_arch("hold.retire", 6'd1, 8'h05, 2'd0, 1'b1, 1'b0);
    // en low right after a retire must drop the pulse
    en = 1'b0;
    tick();
    check_arch("hold.done_drop", 6'd1, 8'h05, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_arch($sformatf("jloop.f%0d", i), 6'd2, 8'h05, 2'd1, 1'b0, 1'b0);
      tick();
      check_arch($sformatf("jloop.d%0d", i), 6'd1, 8'h05, 2'd0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
